// File: rtl/rst_seq_gen_if.sv
// Control/status bundle of the reset sequencer.
//   sw_rst    : synchronous request to re-run the release sequence
//   rst_n_out : per-domain active-low resets, bit k = domain k
//   clka_en   : one-cycle enable pulse for the slow memory domain
//   seq_done  : all domains released
//   state     : debug view of the sequencer (0 SYNC, 1 HOLD, 2 RELEASE, 3 RUN)
interface rst_seq_gen_if #(
    parameter int unsigned NCH = 2
);
    logic           sw_rst;
    logic [NCH-1:0] rst_n_out;
    logic           clka_en;
    logic           seq_done;
    logic [1:0]     state;

    modport master (input sw_rst, output rst_n_out, clka_en, seq_done, state);
    modport slave  (output sw_rst, input rst_n_out, clka_en, seq_done, state);
endinterface

// File: rtl/rst_seq_gen.sv
// Reset and clock-enable sequencer for the MIPS top.
// Synchronises the board reset, holds every domain in reset for HOLD cycles,
// then releases NCH domains in index order STAGGER cycles apart, and produces
// a free-running clka_en pulse every DIV cycles.
//   clk   : system clock, rising edge
//   reset : asynchronous active-low board reset
//   bus   : sw_rst in; rst_n_out, clka_en, seq_done, state out (all registered)
module rst_seq_gen #(
    parameter int unsigned NCH     = 2,
    parameter int unsigned HOLD    = 100,
    parameter int unsigned STAGGER = 4,
    parameter int unsigned DIV     = 2,
    parameter int unsigned CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    rst_seq_gen_if.master bus
);
    localparam int unsigned IW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] ST_SYNC    = 2'd0;
    localparam logic [1:0] ST_HOLD    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;
    localparam logic [1:0] ST_RUN     = 2'd3;

    logic [1:0]     sync_q;
    logic           rst_sync;
    logic [1:0]     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [NCH-1:0] rel_q, rel_d;
    logic           done_q, done_d;
    logic [CW-1:0]  ph_q;
    logic           clka_q;

    assign rst_sync = sync_q[1];

    // Two-flop reset synchroniser: assertion is immediate, release lands on E2.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    // Sequencer state and release registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            idx_q   <= '0;
            rel_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rel_q   <= rel_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; a software re-run request overrides everything past SYNC.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rel_d   = rel_q;
        done_d  = done_q;

        case (state_q)
            ST_SYNC: begin
                // sync_q[0] high means rst_sync rises on this same edge, so HOLD starts at E2.
                if (sync_q[0]) begin
                    state_d = ST_HOLD;
                    cnt_d   = '0;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CW'(HOLD - 1)) begin
                    cnt_d = '0;
                    rel_d = NCH'(1);
                    idx_d = IW'(1);
                    if (NCH == 1) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RELEASE: begin
                if (cnt_q == CW'(STAGGER - 1)) begin
                    cnt_d = '0;
                    rel_d = rel_q | (NCH'(1) << idx_q);
                    if (idx_q == IW'(NCH - 1)) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
            end
        endcase

        if (bus.sw_rst && (state_q != ST_SYNC)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            idx_d   = '0;
            rel_d   = '0;
            done_d  = 1'b0;
        end
    end

    // Free-running clka_en divider, started by rst_sync and blind to sw_rst.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ph_q   <= '0;
            clka_q <= 1'b0;
        end else if (!rst_sync) begin
            ph_q   <= '0;
            clka_q <= 1'b0;
        end else if (ph_q == CW'(DIV - 1)) begin
            ph_q   <= '0;
            clka_q <= 1'b1;
        end else begin
            ph_q   <= ph_q + CW'(1);
            clka_q <= 1'b0;
        end
    end

    assign bus.rst_n_out = rel_q;
    assign bus.seq_done  = done_q;
    assign bus.state     = state_q;
    assign bus.clka_en   = clka_q;
endmodule

// File: tb/tb_rst_seq_gen.sv
// Bench for rst_seq_gen: four parameterisations share clock and board reset,
// each with its own sw_rst; outputs are compared every cycle against a model
// that derives release times from edge numbers.
`timescale 1ns/1ps
module tb_rst_seq_gen;
    localparam int NI = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic sw [NI];

    always #5 clk = ~clk;

    rst_seq_gen_if #(.NCH(2)) bus0 ();
    rst_seq_gen_if #(.NCH(2)) bus1 ();
    rst_seq_gen_if #(.NCH(4)) bus2 ();
    rst_seq_gen_if #(.NCH(1)) bus3 ();

    rst_seq_gen #(.NCH(2), .HOLD(100), .STAGGER(4), .DIV(2), .CW(16)) u0 (.clk(clk), .reset(reset), .bus(bus0));
    rst_seq_gen #(.NCH(2), .HOLD(100), .STAGGER(4), .DIV(1), .CW(16)) u1 (.clk(clk), .reset(reset), .bus(bus1));
    rst_seq_gen #(.NCH(4), .HOLD(3),   .STAGGER(1), .DIV(3), .CW(16)) u2 (.clk(clk), .reset(reset), .bus(bus2));
    rst_seq_gen #(.NCH(1), .HOLD(3),   .STAGGER(1), .DIV(5), .CW(16)) u3 (.clk(clk), .reset(reset), .bus(bus3));

    assign bus0.sw_rst = sw[0];
    assign bus1.sw_rst = sw[1];
    assign bus2.sw_rst = sw[2];
    assign bus3.sw_rst = sw[3];

    logic [15:0] o_rn [NI];
    logic        o_ce [NI];
    logic        o_dn [NI];
    logic [1:0]  o_st [NI];

    assign o_rn[0] = 16'(bus0.rst_n_out);
    assign o_rn[1] = 16'(bus1.rst_n_out);
    assign o_rn[2] = 16'(bus2.rst_n_out);
    assign o_rn[3] = 16'(bus3.rst_n_out);
    assign o_ce[0] = bus0.clka_en;
    assign o_ce[1] = bus1.clka_en;
    assign o_ce[2] = bus2.clka_en;
    assign o_ce[3] = bus3.clka_en;
    assign o_dn[0] = bus0.seq_done;
    assign o_dn[1] = bus1.seq_done;
    assign o_dn[2] = bus2.seq_done;
    assign o_dn[3] = bus3.seq_done;
    assign o_st[0] = bus0.state;
    assign o_st[1] = bus1.state;
    assign o_st[2] = bus2.state;
    assign o_st[3] = bus3.state;

    // Model: j = edge number since reset release (E1 = 1), a[i] = edge that
    // anchors the release schedule (E2 after power-up, last sampled sw_rst edge).
    int j = 0;
    int a [NI];

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            j <= 0;
        end else begin
            j <= j + 1;
            for (int i = 0; i < NI; i++) begin
                if (j + 1 == 2) a[i] <= 2;
                else if (j + 1 >= 3 && sw[i]) a[i] <= j + 1;
            end
        end
    end

    function automatic void params(input int i, output int nch, output int hold, output int stg, output int div);
        case (i)
            0:       begin nch = 2; hold = 100; stg = 4; div = 2; end
            1:       begin nch = 2; hold = 100; stg = 4; div = 1; end
            2:       begin nch = 4; hold = 3;   stg = 1; div = 3; end
            default: begin nch = 1; hold = 3;   stg = 1; div = 5; end
        endcase
    endfunction

    function automatic void model(input int i, output logic [15:0] rn, output logic ce,
                                  output logic dn, output logic [1:0] st);
        int nch, hold, stg, div, d, r;
        params(i, nch, hold, stg, div);
        rn = '0;
        ce = 1'b0;
        dn = 1'b0;
        st = 2'd0;
        if (reset && j >= 2) begin
            d = j - a[i];
            r = (d < hold) ? 0 : (d - hold) / stg + 1;
            if (r > nch) r = nch;
            rn = 16'((1 << r) - 1);
            dn = (r == nch);
            st = (d < hold) ? 2'd1 : (dn ? 2'd3 : 2'd2);
            ce = (j >= 3) && (((j - 2) % div) == 0);
        end
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", tag, got, exp, j, $time);
        end
    endtask

    task automatic check_all();
        logic [15:0] rn;
        logic        ce, dn;
        logic [1:0]  st;
        for (int i = 0; i < NI; i++) begin
            model(i, rn, ce, dn, st);
            chk($sformatf("u%0d.rst_n_out", i), 32'(o_rn[i]), 32'(rn));
            chk($sformatf("u%0d.clka_en", i), 32'(o_ce[i]), 32'(ce));
            chk($sformatf("u%0d.seq_done", i), 32'(o_dn[i]), 32'(dn));
            chk($sformatf("u%0d.state", i), 32'(o_st[i]), 32'(st));
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Advance to the negedge following edge `target`, bounded.
    task automatic goto(input int target);
        for (int k = 0; k < 1000 && j != target; k++) step();
        if (j != target) chk("goto_timeout", 32'(j), 32'(target));
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int rst_hold;
        for (int i = 0; i < NI; i++) begin
            sw[i] = 1'b0;
            a[i]  = 0;
        end

        // Power-up: board reset held low, then released.
        run(10);
        reset = 1'b1;
        goto(120);

        // Software re-run sampled at E200 on every instance.
        goto(199);
        for (int i = 0; i < NI; i++) sw[i] = 1'b1;
        step();
        for (int i = 0; i < NI; i++) sw[i] = 1'b0;
        goto(310);

        // Asynchronous reset between the two default-channel releases.
        reset = 1'b0;
        run(3);
        reset = 1'b1;
        goto(104);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async.u0.rst_n_out", 32'(o_rn[0]), 32'd0);
        chk("async.u0.seq_done", 32'(o_dn[0]), 32'd0);
        chk("async.u0.state", 32'(o_st[0]), 32'd0);
        chk("async.u1.clka_en", 32'(o_ce[1]), 32'd0);
        chk("async.u2.rst_n_out", 32'(o_rn[2]), 32'd0);
        run(2);
        reset = 1'b1;
        goto(110);

        // Sub-cycle reset glitch between edges.
        @(posedge clk);
        #2 reset = 1'b0;
        #2 reset = 1'b1;
        #0.5;
        chk("glitch.u0.rst_n_out", 32'(o_rn[0]), 32'd0);
        chk("glitch.u3.seq_done", 32'(o_dn[3]), 32'd0);
        chk("glitch.u1.clka_en", 32'(o_ce[1]), 32'd0);

        // sw_rst on the final-release edge E106 of the default instance.
        goto(105);
        sw[0] = 1'b1;
        step();
        sw[0] = 1'b0;
        goto(212);

        // Randomised sw_rst requests and occasional board-reset pulses.
        rst_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NI; i++) begin
                if (sw[i]) sw[i] = ($urandom_range(0, 2) == 0);
                else       sw[i] = ($urandom_range(0, 119) == 0);
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) reset = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                reset    = 1'b0;
                rst_hold = int'($urandom_range(1, 3));
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/rst_seq_gen.md
# rst_seq_gen

Parametrised reset and clock-enable sequencer for the MIPS top. Replaces the fixed "hold reset, then release" power-up sequence with a synthesizable block that synchronises the board reset and holds the core in reset for a programmable interval. It then releases NCH reset domains one after another (core, memories, peripherals) and generates the divided `clka` enable for the slow memory domain. It also supports a software-requested re-run of the whole sequence.

## Interface
- `NCH`, 2: number of reset output channels (1..16).
- `HOLD`, 100: cycles from synchronised reset release to channel 0 release (≥1).
- `STAGGER`, 4: cycles between successive channel releases (≥1).
- `DIV`, 2: `clka_en` period in clk cycles (≥1; 1 means always high after start).
- `CW`, 16: internal counter width; must hold max(HOLD, STAGGER, DIV).
- `clk` in 1: single system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronised internally.
- `sw_rst` in 1: synchronous, active-high request to re-run the sequence.
- `rst_n_out` out NCH: per-channel active-low reset; bit k belongs to domain k.
- `clka_en` out 1: one-cycle enable pulse every DIV cycles.
- `seq_done` out 1: high once all channels are released.
- `state` out 2: debug encoding, 0=SYNC, 1=HOLD, 2=RELEASE, 3=RUN.

## Operation
- The reset synchroniser is two flops, cleared asynchronously by `reset`=0. `rst_sync` goes high on the 2nd rising edge with `reset`=1.
- The edges are numbered E1, E2, … from the first rising edge with `reset`=1. `rst_sync` rises at E2.
- While `reset`=0, all of the following hold asynchronously:
  - `rst_n_out`=0, `clka_en`=0, `seq_done`=0.
  - `state`=SYNC, and all counters are 0.
- State machine:
  - **SYNC**: go to HOLD when `rst_sync`=1, which happens at E2.
  - **HOLD**: count cycles. On the edge that completes HOLD cycles, set `rst_n_out[0]`=1 and go to RELEASE. If NCH=1, go directly to RUN instead.
  - **RELEASE**: count STAGGER cycles per channel and set the next bit of `rst_n_out` on each completion. On the edge that releases bit NCH-1, go to RUN and set `seq_done`=1 on that same edge.
  - **RUN**: stay until `sw_rst` or `reset`.
- `rst_n_out` bits release strictly in index order and never deassert out of order. A bit that has been released stays 1 until `sw_rst` or `reset`.
- `sw_rst` behaviour:
  - Sampled at every edge in HOLD, RELEASE or RUN.
  - On an edge S with `sw_rst`=1: `rst_n_out`<=0, `seq_done`<=0, `state`<=HOLD, and the HOLD/STAGGER counters are cleared.
  - The sequence then restarts, timed relative to the last edge at which `sw_rst` was sampled high.
  - Holding `sw_rst` high keeps the block in HOLD with all channels in reset.
  - `sw_rst` is ignored in SYNC.
- `clka_en` divider:
  - Runs freely once `rst_sync`=1 and is not affected by `sw_rst`.
  - The phase counter counts 0..DIV-1 and wraps.
  - `clka_en` is registered high for one cycle on each wrap.

## Timing
- Outputs that are registered: `rst_n_out`, `clka_en`, `seq_done`, `state`.
- Power-up release edges:
  - Channel k releases at edge E(2+HOLD+k·STAGGER).
  - `seq_done` rises at E(2+HOLD+(NCH-1)·STAGGER).
- `sw_rst` release edges, with S the last edge at which `sw_rst` was sampled high:
  - Channel k releases at S+HOLD+k·STAGGER.
  - `seq_done` rises at S+HOLD+(NCH-1)·STAGGER.
- `clka_en` timing:
  - It is high in the cycle after edges E(2+DIV), E(2+2·DIV), …
  - With DIV=1 it is continuously high after E3.
- Reset mid-sequence: `reset`=0 at any time drives all outputs to 0 immediately, without waiting for a clock edge. The full sequence, including the 2-flop sync, restarts when `reset` returns to 1.
- A `reset` glitch shorter than one clk period still clears the block completely. Deassertion is never observed before E2.
- `sw_rst` and the final release on the same edge: `sw_rst` wins, so all channels go to 0 and `seq_done` stays 0.

## Test plan
- **Power-up, defaults**: `reset`=0 for 100 ns, then 1.
  - `rst_n_out`=00 until E102.
  - `rst_n_out`=01 at E102 and 11 at E106.
  - `seq_done`=1 at E106 and `state`=3.
- **clka_en, DIV=2**: pulses after E4, E6, E8, …, one cycle wide with exactly 1 idle cycle between pulses. Repeat with DIV=1: continuously high after E3.
- **sw_rst during RUN**: one-cycle `sw_rst` at edge S=200.
  - `rst_n_out`=00 and `seq_done`=0 after S.
  - Bit 0 releases at S+100=300 and bit 1 at 304.
  - `clka_en` phase is unchanged.
- **Asynchronous reset mid-RELEASE**: drive `reset`=0 between E102 and E106.
  - All outputs go to 0 before the next edge.
  - After re-release, the release edges again fall at E102/E106, counted from the new E1.
- **Parameter sweep NCH=4, HOLD=3, STAGGER=1**:
  - Releases at E5, E6, E7, E8, in strict bit order.
  - `seq_done` at E8.
  - With NCH=1, bit 0 releases and `seq_done` rises together at E5.
- **sw_rst on the final-release edge**: assert `sw_rst` at E106 (defaults).
  - `rst_n_out[1]` never rises and `seq_done` stays 0.
  - Bit 0 re-releases at 206 and bit 1 at 210.
